// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count and overflow/underflow pulses
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  assign full   = count == (AW+1)'(DEPTH);
  assign empty  = count == '0;
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  always_ff @(posedge clk)
    if (!rst && wr_acc) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo at WIDTH=8, DEPTH=8
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst, wr_en, rd_en, full, empty, overflow, underflow;
  logic [7:0] din, dout;
  logic [3:0] count;
  int total = 0;
  int bad = 0;
  sync_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    tick();
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {overflow, underflow}); end
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h77;
    tick();
    total++; if (count !== 4'd0 || {overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_priority got count=%0d flags=%b exp count=0 flags=00", count, {overflow, underflow}); end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    total++; if (empty !== 1'b1 || count !== 4'd0 || {overflow, underflow} !== 2'b00) begin bad++; $display("FAIL idle got empty=%b count=%0d flags=%b exp 1/0/00", empty, count, {overflow, underflow}); end
  endtask
  task automatic test_fill_drain;
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      din = 8'(i);
      tick();
    end
    total++; if (full !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL fill got full=%b count=%0d exp 1/8", full, count); end
    din = 8'hFF;
    tick();
    total++; if (overflow !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL overflow got ovf=%b count=%0d exp 1/8", overflow, count); end
    wr_en = 1'b0;
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_pulse got=%b exp=0", overflow); end
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (dout !== 8'(i)) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, dout, 8'(i)); end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count); end
  endtask
  task automatic test_underflow;
    rd_en = 1'b1;
    tick();
    total++; if (underflow !== 1'b1 || dout !== 8'h08 || count !== 4'd0) begin bad++; $display("FAIL underflow got unf=%b dout=%h count=%0d exp 1/08/0", underflow, dout, count); end
    rd_en = 1'b0;
    tick();
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_pulse got=%b exp=0", underflow); end
  endtask
  task automatic test_simultaneous;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'h10 + 8'(i);
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'h13 + 8'(i);
      tick();
      total++; if (count !== 4'd3 || dout !== 8'h10 + 8'(i)) begin bad++; $display("FAIL rw_steady_%0d got count=%0d dout=%h exp 3/%h", i, count, dout, 8'h10 + 8'(i)); end
    end
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 8'h18 + 8'(i);
      tick();
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL rw_prefull got=%b exp=1", full); end
    rd_en = 1'b1; din = 8'hEE;
    tick();
    total++; if (count !== 4'd7 || overflow !== 1'b1 || dout !== 8'h15) begin bad++; $display("FAIL rw_full got count=%0d ovf=%b dout=%h exp 7/1/15", count, overflow, dout); end
    wr_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++; if (dout !== 8'h16 + 8'(i)) begin bad++; $display("FAIL rw_drain_%0d got=%h exp=%h", i, dout, 8'h16 + 8'(i)); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rw_drained got=%b exp=1", empty); end
    wr_en = 1'b1; din = 8'h33;
    tick();
    total++; if (count !== 4'd1 || underflow !== 1'b1 || dout !== 8'h1C) begin bad++; $display("FAIL rw_empty got count=%0d unf=%b dout=%h exp 1/1/1c", count, underflow, dout); end
    wr_en = 1'b0;
    tick();
    total++; if (dout !== 8'h33 || empty !== 1'b1) begin bad++; $display("FAIL rw_empty_data got dout=%h empty=%b exp 33/1", dout, empty); end
    rd_en = 1'b0;
  endtask
  task automatic test_wrap;
    logic [7:0] q[$];
    logic [7:0] exp;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; din = 8'h40 + 8'(i * 3);
      q.push_back(din);
      tick();
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp = q.pop_front();
      total++; if (dout !== exp) begin bad++; $display("FAIL wrap_%0d got=%h exp=%h", i, dout, exp); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask
  task automatic test_mid_reset;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'h50 + 8'(i);
      tick();
    end
    total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_pre got=%0d exp=5", count); end
    rst = 1'b1; din = 8'h99;
    tick();
    rst = 1'b0; wr_en = 1'b0;
    total++; if (count !== 4'd0 || empty !== 1'b1 || dout !== 8'h00) begin bad++; $display("FAIL mid_reset got count=%0d empty=%b dout=%h exp 0/1/00", count, empty, dout); end
    wr_en = 1'b1; din = 8'hA5;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (dout !== 8'hA5 || empty !== 1'b1) begin bad++; $display("FAIL mid_after got dout=%h empty=%b exp a5/1", dout, empty); end
  endtask
  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the data word width in bits (WIDTH >= 1).
REQ-002 The module SHALL have parameter DEPTH, default 8, which sets the number of storage entries (a power of two, DEPTH >= 2).
REQ-003 The module SHALL have port clk  input  1  as its single clock; all state SHALL update on the rising edge of clk.
REQ-004 The module SHALL have port rst  input  1  as its reset, which is synchronous and active-high.
REQ-005 The module SHALL have port wr_en  input  1  as the write request.
REQ-006 The module SHALL have port din  input  WIDTH  as the write data.
REQ-007 The module SHALL have port rd_en  input  1  as the read request.
REQ-008 The module SHALL have port dout  output  WIDTH  as the registered read data.
REQ-009 The module SHALL have port full  output  1  which is high when count == DEPTH.
REQ-010 The module SHALL have port empty  output  1  which is high when count == 0.
REQ-011 The module SHALL have port count  output  $clog2(DEPTH)+1  as the current occupancy.
REQ-012 The module SHALL have port overflow  output  1  as a one-cycle pulse for a rejected write.
REQ-013 The module SHALL have port underflow  output  1  as a one-cycle pulse for a rejected read.

Function
REQ-014 Write accept SHALL be defined as wr_en && !full, sampled at the rising edge; on acceptance, mem[wr_ptr] <= din and wr_ptr advances by 1.
REQ-015 Read accept SHALL be defined as rd_en && !empty, sampled at the rising edge; on acceptance, dout <= mem[rd_ptr] and rd_ptr advances by 1.
REQ-016 Read latency SHALL be one edge: data is visible on dout after the same edge that accepts the read.
REQ-017 dout SHALL hold its last value whenever no read is accepted.
REQ-018 wr_ptr and rd_ptr SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 with no gap or skipped entry.
REQ-019 count SHALL update on every edge as follows:
  - +1 on write accept only
  - -1 on read accept only
  - unchanged when both are accepted or neither is
REQ-020 full and empty SHALL be derived combinationally from count and SHALL reflect the state after the latest edge.
REQ-021 When full and wr_en=1 and rd_en=1 on the same edge, the read SHALL be accepted and the write rejected (overflow=1); count then becomes DEPTH-1.
REQ-022 When empty and wr_en=1 and rd_en=1 on the same edge, the write SHALL be accepted and the read rejected (underflow=1); count then becomes 1 and dout is unchanged.
REQ-023 overflow SHALL be registered and SHALL be 1 for exactly the cycle following an edge where wr_en && full; otherwise it is 0.
REQ-024 underflow SHALL be registered and SHALL be 1 for exactly the cycle following an edge where rd_en && empty; otherwise it is 0.
REQ-025 A rejected request SHALL change no pointer, no count and no memory entry.
REQ-026 Data SHALL exit in strict first-in first-out order across any number of pointer wraps.
REQ-027 The module SHALL contain no latches and no combinational path from din to dout.

Reset
REQ-028 On an edge with rst=1, the module SHALL set wr_ptr=0, rd_ptr=0, count=0, dout=0, overflow=0 and underflow=0, so that empty=1 and full=0.
REQ-029 rst SHALL take priority over wr_en and rd_en on the same edge; neither request is accepted and no flag pulses.
REQ-030 Memory contents need not be cleared; stale entries SHALL never appear on dout after reset until they are rewritten and read.
REQ-031 Reset asserted mid-operation, including while full, SHALL discard all queued data; the first read after release returns the first word written after release.

Verification
REQ-032 The bench SHALL cover reset then idle: rst=1 for 2 edges -> empty=1, full=0, count=0, dout=0, no flag pulses.
REQ-033 The bench SHALL cover fill and drain at DEPTH=8: write 0x01..0x08 -> full=1 and count=8; a 9th write (0xFF) -> overflow pulses once and count stays 8; then read 8 times -> dout sequence 0x01..0x08, empty=1.
REQ-034 The bench SHALL cover read on empty: rd_en=1 with empty=1 -> underflow=1 for one cycle, dout unchanged, count=0.
REQ-035 The bench SHALL cover simultaneous read and write: with count=3, wr_en=rd_en=1 for 5 edges -> count stays 3 and output order is preserved; with full, wr_en=rd_en=1 -> count=7 and overflow=1; with empty, wr_en=rd_en=1 -> count=1 and underflow=1.
REQ-036 The bench SHALL cover wrap-around: 20 interleaved write/read pairs over DEPTH=8 -> every dout matches a reference queue.
REQ-037 The bench SHALL cover reset mid-operation: with count=5, rst=1 for 1 edge while wr_en=1 -> count=0 and empty=1; then write 0xA5 and read -> dout=0xA5.
